// File: rtl/bsg_gateway_power_sequencer_if.sv
// rtl/bsg_gateway_power_sequencer_if.sv - control/status bundle between lifesupport logic and the power sequencer
interface bsg_gateway_power_sequencer_if;
   logic       power_on_i;
   logic       fault_i;
   logic       clear_i;
   logic       asic_io_en_o;
   logic       asic_core_en_o;
   logic       asic_reset_o;
   logic       ready_o;
   logic       fault_o;
   logic [2:0] state_o;

   modport master (
      output power_on_i, fault_i, clear_i,
      input  asic_io_en_o, asic_core_en_o, asic_reset_o, ready_o, fault_o, state_o
   );

   modport slave (
      input  power_on_i, fault_i, clear_i,
      output asic_io_en_o, asic_core_en_o, asic_reset_o, ready_o, fault_o, state_o
   );
endinterface

// File: rtl/bsg_gateway_power_sequencer.sv
// rtl/bsg_gateway_power_sequencer.sv - ASIC rail and reset sequencer with fault shutdown
module bsg_gateway_power_sequencer #(
   parameter int io_delay_p   = 1000,
   parameter int core_delay_p = 1000,
   parameter int reset_hold_p = 16,
   parameter int down_delay_p = 100
) (
   input logic                          clk_i,
   input logic                          reset_i,
   bsg_gateway_power_sequencer_if.slave ctl
);

   localparam int max_up_lp    = (io_delay_p > core_delay_p) ? io_delay_p : core_delay_p;
   localparam int max_other_lp = (reset_hold_p > down_delay_p) ? reset_hold_p : down_delay_p;
   localparam int max_delay_lp = (max_up_lp > max_other_lp) ? max_up_lp : max_other_lp;
   localparam int cnt_w_lp     = $clog2(max_delay_lp + 1);

   // Each timed state loads delay-1 on entry and exits on zero, so it lasts exactly delay cycles.
   localparam logic [cnt_w_lp-1:0] io_load_lp   = cnt_w_lp'(io_delay_p - 1);
   localparam logic [cnt_w_lp-1:0] core_load_lp = cnt_w_lp'(core_delay_p - 1);
   localparam logic [cnt_w_lp-1:0] hold_load_lp = cnt_w_lp'(reset_hold_p - 1);
   localparam logic [cnt_w_lp-1:0] down_load_lp = cnt_w_lp'(down_delay_p - 1);

   typedef enum logic [2:0] {
      off_s        = 3'd0,
      io_up_s      = 3'd1,
      core_up_s    = 3'd2,
      reset_hold_s = 3'd3,
      on_s         = 3'd4,
      core_down_s  = 3'd5,
      io_down_s    = 3'd6,
      fault_s      = 3'd7
   } state_e;

   state_e                state_r, state_n;
   logic [cnt_w_lp-1:0]   cnt_r, cnt_n;
   logic                  fault_r, fault_n;
   logic                  expired;

   assign expired = (cnt_r == '0);

   // State, timer and sticky fault registers; reset drops the rails at once without sequencing.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= off_s;
         cnt_r   <= '0;
         fault_r <= 1'b0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         fault_r <= fault_n;
      end
   end

   // Next-state: fault first, then abort (power_on low), then timer expiry.
   always_comb begin
      state_n = state_r;
      fault_n = fault_r;
      if (ctl.fault_i && (state_r != fault_s)) begin
         state_n = fault_s;
         fault_n = 1'b1;
      end else begin
         case (state_r)
            off_s:        if (ctl.power_on_i) state_n = io_up_s;
            io_up_s:      if (!ctl.power_on_i) state_n = io_down_s;
                          else if (expired) state_n = core_up_s;
            core_up_s:    if (!ctl.power_on_i) state_n = core_down_s;
                          else if (expired) state_n = reset_hold_s;
            reset_hold_s: if (!ctl.power_on_i) state_n = core_down_s;
                          else if (expired) state_n = on_s;
            on_s:         if (!ctl.power_on_i) state_n = core_down_s;
            core_down_s:  if (expired) state_n = io_down_s;
            io_down_s:    if (expired) state_n = off_s;
            fault_s: begin
               // Leaving FAULT needs the host to have withdrawn the power request.
               if (ctl.clear_i && !ctl.fault_i && !ctl.power_on_i) begin
                  state_n = off_s;
                  fault_n = 1'b0;
               end
            end
            default:      state_n = off_s;
         endcase
      end
   end

   // Timer: reload on entry to a timed state, otherwise count down to zero and hold.
   always_comb begin
      cnt_n = cnt_r;
      if (state_n != state_r) begin
         case (state_n)
            io_up_s:                cnt_n = io_load_lp;
            core_up_s:              cnt_n = core_load_lp;
            reset_hold_s:           cnt_n = hold_load_lp;
            core_down_s, io_down_s: cnt_n = down_load_lp;
            default:                cnt_n = '0;
         endcase
      end else if (cnt_r != '0) begin
         cnt_n = cnt_r - 1'b1;
      end
   end

   // Moore output decode of the state register.
   always_comb begin
      ctl.asic_io_en_o   = 1'b0;
      ctl.asic_core_en_o = 1'b0;
      ctl.asic_reset_o   = 1'b1;
      ctl.ready_o        = 1'b0;
      ctl.fault_o        = fault_r;
      ctl.state_o        = state_r;
      case (state_r)
         io_up_s, core_down_s: ctl.asic_io_en_o = 1'b1;
         core_up_s, reset_hold_s: begin
            ctl.asic_io_en_o   = 1'b1;
            ctl.asic_core_en_o = 1'b1;
         end
         on_s: begin
            ctl.asic_io_en_o   = 1'b1;
            ctl.asic_core_en_o = 1'b1;
            ctl.asic_reset_o   = 1'b0;
            ctl.ready_o        = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bsg_gateway_power_sequencer.sv
// tb/tb_bsg_gateway_power_sequencer.sv - scoreboard bench for the ASIC power sequencer
module tb_bsg_gateway_power_sequencer;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   total = 0;
   int   passed = 0;

   bsg_gateway_power_sequencer_if bus();

   bsg_gateway_power_sequencer #(
      .io_delay_p  (4),
      .core_delay_p(3),
      .reset_hold_p(2),
      .down_delay_p(2)
   ) dut (
      .clk_i  (clk),
      .reset_i(reset),
      .ctl    (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         c;
      logic [7:0] v;
      string      name;
   } exp_t;

   exp_t q[$];

   // Expected pack: {io_en, core_en, asic_reset, ready, fault, state[2:0]}
   task automatic expect_at(input int c, input logic io, input logic core, input logic rst,
                            input logic rdy, input logic flt, input logic [2:0] st, input string name);
      exp_t e;
      e.c    = c;
      e.v    = {io, core, rst, rdy, flt, st};
      e.name = name;
      q.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: on each falling edge pop every expectation due this cycle and compare.
   always @(negedge clk) begin
      logic [7:0] act;
      act = {bus.asic_io_en_o, bus.asic_core_en_o, bus.asic_reset_o,
             bus.ready_o, bus.fault_o, bus.state_o};
      while (q.size() > 0 && q[0].c <= cyc) begin
         exp_t e;
         e = q.pop_front();
         total++;
         if (e.c < cyc)
            $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.c, cyc);
         else if (act !== e.v)
            $display("FAIL %s @%0d: got io/core/rst/rdy/flt/st=%b required %b", e.name, cyc, act, e.v);
         else
            passed++;
      end
   end

   task automatic power_up_seq(input string tag);
      int b;
      b = cyc;
      bus.power_on_i = 1'b1;
      expect_at(b + 1,  1, 0, 1, 0, 0, 3'd1, {tag, "_io_up"});
      expect_at(b + 4,  1, 0, 1, 0, 0, 3'd1, {tag, "_io_up_last"});
      expect_at(b + 5,  1, 1, 1, 0, 0, 3'd2, {tag, "_core_up"});
      expect_at(b + 7,  1, 1, 1, 0, 0, 3'd2, {tag, "_core_up_last"});
      expect_at(b + 8,  1, 1, 1, 0, 0, 3'd3, {tag, "_reset_hold"});
      expect_at(b + 9,  1, 1, 1, 0, 0, 3'd3, {tag, "_reset_hold_last"});
      expect_at(b + 10, 1, 1, 0, 1, 0, 3'd4, {tag, "_on"});
      wait_until(b + 10);
   endtask

   initial begin
      int b;
      reset          = 1'b1;
      bus.power_on_i = 1'b0;
      bus.fault_i    = 1'b0;
      bus.clear_i    = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      expect_at(cyc, 0, 0, 1, 0, 0, 3'd0, "reset_state");
      @(posedge clk);
      #1;
      reset = 1'b0;
      wait_until(cyc + 2);

      // Scenario 1: full power-up
      power_up_seq("pu1");

      // Scenario 2: orderly power-down from ON
      b = cyc;
      bus.power_on_i = 1'b0;
      expect_at(b + 1, 1, 0, 1, 0, 0, 3'd5, "pd_core_down");
      expect_at(b + 2, 1, 0, 1, 0, 0, 3'd5, "pd_core_down_last");
      expect_at(b + 3, 0, 0, 1, 0, 0, 3'd6, "pd_io_down");
      expect_at(b + 5, 0, 0, 1, 0, 0, 3'd0, "pd_off");
      wait_until(b + 7);

      // Scenario 3: abort during IO_UP
      b = cyc;
      bus.power_on_i = 1'b1;
      expect_at(b + 1, 1, 0, 1, 0, 0, 3'd1, "abort_io_up");
      expect_at(b + 2, 1, 0, 1, 0, 0, 3'd1, "abort_io_up2");
      wait_until(b + 2);
      bus.power_on_i = 1'b0;
      expect_at(b + 3, 0, 0, 1, 0, 0, 3'd6, "abort_io_down");
      expect_at(b + 4, 0, 0, 1, 0, 0, 3'd6, "abort_io_down_last");
      expect_at(b + 5, 0, 0, 1, 0, 0, 3'd0, "abort_off");
      wait_until(b + 6);

      // Scenario 4: fault in ON, power request ignored, then clear
      power_up_seq("pu2");
      b = cyc;
      bus.fault_i = 1'b1;
      expect_at(b + 1, 0, 0, 1, 0, 1, 3'd7, "fault_enter");
      wait_until(b + 1);
      bus.fault_i = 1'b0;
      expect_at(b + 3, 0, 0, 1, 0, 1, 3'd7, "fault_hold_pwr_on");
      wait_until(b + 3);
      bus.power_on_i = 1'b0;
      bus.clear_i    = 1'b1;
      expect_at(b + 4, 0, 0, 1, 0, 0, 3'd0, "fault_cleared");
      wait_until(b + 4);
      bus.clear_i = 1'b0;
      wait_until(b + 6);

      // Scenario 5: clear blocked by active fault or by power request
      b = cyc;
      bus.fault_i = 1'b1;
      expect_at(b + 1, 0, 0, 1, 0, 1, 3'd7, "fault_from_off");
      wait_until(b + 1);
      bus.clear_i = 1'b1;
      expect_at(b + 2, 0, 0, 1, 0, 1, 3'd7, "clear_with_fault");
      wait_until(b + 2);
      bus.fault_i    = 1'b0;
      bus.clear_i    = 1'b0;
      bus.power_on_i = 1'b1;
      wait_until(b + 3);
      bus.clear_i = 1'b1;
      expect_at(b + 4, 0, 0, 1, 0, 1, 3'd7, "clear_with_pwr_on");
      wait_until(b + 4);
      bus.clear_i    = 1'b0;
      bus.power_on_i = 1'b0;
      wait_until(b + 5);
      bus.clear_i = 1'b1;
      expect_at(b + 6, 0, 0, 1, 0, 0, 3'd0, "clear_ok");
      wait_until(b + 6);
      bus.clear_i = 1'b0;
      wait_until(b + 8);

      // Scenario 6: synchronous reset in CORE_UP, then a clean repeat power-up
      b = cyc;
      bus.power_on_i = 1'b1;
      expect_at(b + 6, 1, 1, 1, 0, 0, 3'd2, "rst_core_up");
      wait_until(b + 6);
      reset          = 1'b1;
      bus.power_on_i = 1'b0;
      expect_at(b + 7, 0, 0, 1, 0, 0, 3'd0, "rst_mid_op");
      wait_until(b + 7);
      reset = 1'b0;
      wait_until(b + 9);
      power_up_seq("pu3");

      wait_until(cyc + 3);
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         total++;
         $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.c);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench exceeded time limit");
      $display("%0d/%0d checks passed", passed, total + 1);
      $fatal(1);
   end

endmodule
